cdc_4phase_src_arbiter: RTL

Round-robin arbiter that shares one 4-phase CDC source channel among `NUM_REQ` requesters in the source clock domain. It accepts one message at a time from the winning requester and registers it with the requester's ID appended. It then presents the message on a single valid/ready port to a `cdc_4phase_src` instance configured with `DECOUPLED = 1`. The destination side can then de-multiplex messages by ID.

---
 rtl/cdc_src_arb_pkg.sv | 14 +
 rtl/cdc_4phase_src_arbiter_rr_pick.sv | 46 ++++
 rtl/cdc_4phase_src_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cdc_src_arb_pkg.sv
// Shared types and helpers for the round-robin 4-phase CDC source arbiter.
package cdc_src_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_e;

  // Requester tag width; at least one bit so the tag field always exists.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/cdc_4phase_src_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, else lowest set request.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [N-1:0]     hi_req;
  logic             hi_any;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  always_comb begin
    hi_req = '0;
    for (int i = 0; i < N; i++) begin
      hi_req[i] = req[i] && (i >= int'(ptr));
    end
  end

  // Two passes: masked (ptr and above) wins, unmasked covers the wrap.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hi_req[i]) hi_idx = IDX_W'(i);
      if (req[i])    lo_idx = IDX_W'(i);
    end
  end

  assign hi_any    = |hi_req;
  assign any       = |req;
  assign grant_idx = hi_any ? hi_idx : lo_idx;

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (any && (grant_idx == IDX_W'(i))) grant_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cdc_4phase_src_arbiter.sv
// Round-robin arbiter sharing one 4-phase CDC source channel; messages tagged {id, payload}.
// Optional stall watchdog enabled by defining CDC_SRC_ARB_TIMEOUT_EN.
module cdc_4phase_src_arbiter
  import cdc_src_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int ID_W           = id_width(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      cdc_valid_o,
  input  logic                      cdc_ready_i,
  output logic [ID_W+DATA_W-1:0]    cdc_data_o,
  output logic                      timeout_o,
  input  logic                      timeout_clr_i
);

  arb_state_e               state;
  logic [ID_W-1:0]          rr_ptr;
  logic [NUM_REQ-1:0]       grant_onehot;
  logic [ID_W-1:0]          grant_idx;
  logic                     any_req;
  logic [DATA_W-1:0]        grant_data;
  logic                     vld_p1;
  logic [ID_W+DATA_W-1:0]   data_p1;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req          (req_valid_i),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any_req)
  );

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) grant_data = req_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Acceptance strobe is combinational in IDLE and held low while reset is asserted.
  assign req_ready_o = ((state == ARB_IDLE) && !rst_i) ? grant_onehot : '0;

  // Stage p1: registered message and its valid toward the CDC source.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ARB_IDLE;
      rr_ptr  <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            data_p1 <= {grant_idx, grant_data};
            rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            vld_p1  <= 1'b1;
            state   <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          if (cdc_ready_i) begin
            vld_p1 <= 1'b0;
            state  <= ARB_IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= ARB_IDLE;
        end
      endcase
    end
  end

  assign cdc_valid_o = vld_p1;
  assign cdc_data_o  = data_p1;

`ifdef CDC_SRC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_q;

  // Saturating stall counter; the flag is sticky and the clear has priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == ARB_SEND) && !cdc_ready_i) begin
        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= '0;
      end
      if (timeout_clr_i) begin
        timeout_q <= 1'b0;
      end else if ((state == ARB_SEND) && (stall_cnt == CNT_MAX)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = timeout_clr_i ^ (TIMEOUT_CYCLES == 0);
  assign timeout_o = 1'b0;
`endif

endmodule
